// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_IF_WAIT,
      ST_D_WAIT,
      ST_IF_RESP,
      ST_D_RESP
   } arb_state_e;

   localparam logic GRANT_IF = 1'b0;
   localparam logic GRANT_D  = 1'b1;

   localparam int          DEF_ADDR_W  = 32;
   localparam int          DEF_DATA_W  = 32;
   localparam int unsigned DEF_TIMEOUT = 255;

   // Counter width able to hold values 0..max_count.
   function automatic int unsigned timer_width(input int unsigned max_count);
      return $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/acknowledge bus between the arbiter (master) and the unified memory (slave).
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for mem_ack; flags the cycle in which the wait budget runs out.
module mem_wait_timer
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic timeout_o
);
   localparam int unsigned   CW   = timer_width(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Saturates at LAST so a stuck enable can never wrap back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and the MEM stage,
// producing per-stage stalls, flush-based fetch cancellation and alternating tie-break.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int          ADDR_W  = DEF_ADDR_W,
   parameter int          DATA_W  = DEF_DATA_W,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_stall,
   input  logic              pipe_advance,
   output logic              bus_err,
   mem_port_arbiter_if.master mem
);
   arb_state_e        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              bus_err_q, bus_err_d;
   logic              if_served_q, if_served_d;
   logic              d_served_q, d_served_d;
   logic              drop_q, drop_d;
   logic              last_grant_q, last_grant_d;

   logic d_access;
   logic if_pend;
   logic d_pend;
   logic in_wait;
   logic drop_now;
   logic wait_done;
   logic timeout;

   assign d_access  = d_rd | d_wr;
   assign if_pend   = if_req & ~if_served_q & ~if_flush;
   assign d_pend    = d_access & ~d_served_q;
   assign in_wait   = (state_q == ST_IF_WAIT) || (state_q == ST_D_WAIT);
   // A flush arriving in the same cycle as the ack must already discard the word.
   assign drop_now  = drop_q | ((state_q == ST_IF_WAIT) & if_flush);
   assign wait_done = mem.mem_ack | timeout;

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (~in_wait),
      .en_i      (in_wait),
      .timeout_o (timeout)
   );

   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      bus_err_d    = bus_err_q;
      if_served_d  = if_served_q;
      d_served_d   = d_served_q;
      drop_d       = drop_q;
      last_grant_d = last_grant_q;

      case (state_q)
         ST_IDLE: begin
            if (d_pend && (!if_pend || (last_grant_q == GRANT_IF))) begin
               mem_req_d    = 1'b1;
               mem_we_d     = d_wr;
               mem_addr_d   = d_addr;
               mem_wdata_d  = d_wdata;
               last_grant_d = GRANT_D;
               state_d      = ST_D_WAIT;
            end else if (if_pend) begin
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_addr_d   = if_addr;
               last_grant_d = GRANT_IF;
               state_d      = ST_IF_WAIT;
            end
         end
         ST_IF_WAIT: begin
            drop_d = drop_now;
            if (wait_done) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               bus_err_d = bus_err_q | ~mem.mem_ack;
               if (!drop_now) begin
                  if_rdata_d = mem.mem_ack ? mem.mem_rdata : '0;
               end
               state_d = ST_IF_RESP;
            end
         end
         ST_D_WAIT: begin
            if (wait_done) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               bus_err_d = bus_err_q | ~mem.mem_ack;
               d_rdata_d = mem.mem_ack ? mem.mem_rdata : '0;
               state_d   = ST_D_RESP;
            end
         end
         ST_IF_RESP: begin
            if (drop_q) begin
               drop_d = 1'b0;
            end else begin
               if_served_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         ST_D_RESP: begin
            d_served_d = 1'b1;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // An advancing pipeline has consumed the served word, so the flag belongs to the old access.
      if (if_flush || pipe_advance) begin
         if_served_d = 1'b0;
      end
      if (pipe_advance) begin
         d_served_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         bus_err_q    <= 1'b0;
         if_served_q  <= 1'b0;
         d_served_q   <= 1'b0;
         drop_q       <= 1'b0;
         last_grant_q <= GRANT_IF;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         bus_err_q    <= bus_err_d;
         if_served_q  <= if_served_d;
         d_served_q   <= d_served_d;
         drop_q       <= drop_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign if_stall = if_req & ~if_served_q & ~((state_q == ST_IF_RESP) & ~drop_q);
   assign d_stall  = d_access & ~d_served_q & ~(state_q == ST_D_RESP);

   assign if_rdata      = if_rdata_q;
   assign d_rdata       = d_rdata_q;
   assign bus_err       = bus_err_q;
   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays the memory and checks each cycle by hand.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int          AW = 32;
   localparam int          DW = 32;
   localparam int unsigned TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_flush;
   logic [DW-1:0] if_rdata;
   logic          if_stall;
   logic          d_rd;
   logic          d_wr;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_stall;
   logic          pipe_advance;
   logic          bus_err;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

   mem_port_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_flush     (if_flush),
      .if_rdata     (if_rdata),
      .if_stall     (if_stall),
      .d_rd         (d_rd),
      .d_wr         (d_wr),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_rdata      (d_rdata),
      .d_stall      (d_stall),
      .pipe_advance (pipe_advance),
      .bus_err      (bus_err),
      .mem          (mem)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   req_pulses = 0;
   logic req_prev = 1'b0;

   // Rising edges of mem_req, i.e. distinct bus transactions issued.
   always @(posedge clk) begin
      if (mem.mem_req && !req_prev) req_pulses <= req_pulses + 1;
      req_prev <= mem.mem_req;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-22s observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
      d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0; pipe_advance = 1'b0;
      mem.mem_ack = 1'b0; mem.mem_rdata = '0;
      step(); step();
      chk("rst_mem_req",  mem.mem_req,  32'h0);
      chk("rst_mem_we",   mem.mem_we,   32'h0);
      chk("rst_mem_addr", mem.mem_addr, 32'h0);
      chk("rst_if_rdata", if_rdata,     32'h0);
      chk("rst_d_rdata",  d_rdata,      32'h0);
      chk("rst_bus_err",  bus_err,      32'h0);
      chk("rst_stalls",   {if_stall, d_stall}, 32'h0);
      rst = 1'b0;

      // Single load, ack on the fourth wait cycle (the last one before timeout).
      d_rd = 1'b1; d_addr = 32'h100; #1;
      chk("s1_dstall_idle", d_stall, 32'h1);
      step();
      chk("s1_req_c1",  mem.mem_req,  32'h1);
      chk("s1_we_c1",   mem.mem_we,   32'h0);
      chk("s1_addr_c1", mem.mem_addr, 32'h100);
      step(); chk("s1_req_c2", mem.mem_req, 32'h1);
      step(); chk("s1_req_c3", mem.mem_req, 32'h1);
      step();
      mem.mem_ack = 1'b1; mem.mem_rdata = 32'hDEADBEEF; #1;
      chk("s1_dstall_ack", d_stall, 32'h1);
      step(); mem.mem_ack = 1'b0; mem.mem_rdata = '0; #1;
      chk("s1_req_resp",    mem.mem_req, 32'h0);
      chk("s1_d_rdata",     d_rdata,     32'hDEADBEEF);
      chk("s1_dstall_resp", d_stall,     32'h0);
      chk("s1_no_bus_err",  bus_err,     32'h0);
      pipe_advance = 1'b1; step(); pipe_advance = 1'b0; d_rd = 1'b0; #1;
      chk("s1_dstall_after", d_stall, 32'h0);
      step();
      chk("s1_req_idle",   mem.mem_req, 32'h0);
      chk("s1_req_pulses", req_pulses,  32'd1);

      // Store and fetch pending together from reset: store first, issued once.
      rst = 1'b1; step(); rst = 1'b0;
      if_req = 1'b1; if_addr = 32'h40; d_wr = 1'b1; d_addr = 32'h200; d_wdata = 32'hCAFEF00D; #1;
      chk("s2_stalls_both", {if_stall, d_stall}, 32'h3);
      step();
      chk("s2_d_first_req", mem.mem_req,   32'h1);
      chk("s2_d_first_we",  mem.mem_we,    32'h1);
      chk("s2_d_addr",      mem.mem_addr,  32'h200);
      chk("s2_d_wdata",     mem.mem_wdata, 32'hCAFEF00D);
      mem.mem_ack = 1'b1; step(); mem.mem_ack = 1'b0; #1;
      chk("s2_dresp_stalls", {if_stall, d_stall}, 32'h2);
      chk("s2_dresp_req",    mem.mem_req, 32'h0);
      step();
      chk("s2_idle_dstall", d_stall,     32'h0);
      chk("s2_idle_req",    mem.mem_req, 32'h0);
      step();
      chk("s2_if_req",  mem.mem_req,  32'h1);
      chk("s2_if_we",   mem.mem_we,   32'h0);
      chk("s2_if_addr", mem.mem_addr, 32'h40);
      mem.mem_ack = 1'b1; mem.mem_rdata = 32'h00000013; step(); mem.mem_ack = 1'b0; #1;
      chk("s2_if_rdata",    if_rdata, 32'h00000013);
      chk("s2_ifresp_stl",  {if_stall, d_stall}, 32'h0);
      step(); step();
      chk("s2_held_req",    mem.mem_req, 32'h0);
      chk("s2_held_stalls", {if_stall, d_stall}, 32'h0);
      chk("s2_req_pulses",  req_pulses,  32'd3);
      pipe_advance = 1'b1; step(); pipe_advance = 1'b0; #1;
      chk("s2_adv_stalls", {if_stall, d_stall}, 32'h3);
      d_wr = 1'b0; if_req = 1'b0;

      // Continuous load + fetch: grants alternate D, IF, D, IF.
      d_rd = 1'b1; d_addr = 32'h300; if_req = 1'b1; if_addr = 32'h80;
      step();
      chk("s3_g1_d", mem.mem_addr, 32'h300);
      mem.mem_ack = 1'b1; mem.mem_rdata = 32'hA0000300; step(); mem.mem_ack = 1'b0; step(); step();
      chk("s3_g2_if", mem.mem_addr, 32'h80);
      mem.mem_ack = 1'b1; mem.mem_rdata = 32'hA0000080; step(); mem.mem_ack = 1'b0; #1;
      chk("s3_pair1_stalls", {if_stall, d_stall}, 32'h0);
      pipe_advance = 1'b1; step(); pipe_advance = 1'b0; d_addr = 32'h304; if_addr = 32'h84; #1;
      chk("s3_new_stalls", {if_stall, d_stall}, 32'h3);
      step();
      chk("s3_g3_d", mem.mem_addr, 32'h304);
      mem.mem_ack = 1'b1; mem.mem_rdata = 32'hA0000304; step(); mem.mem_ack = 1'b0; step(); step();
      chk("s3_g4_if", mem.mem_addr, 32'h84);
      mem.mem_ack = 1'b1; mem.mem_rdata = 32'hA0000084; step(); mem.mem_ack = 1'b0; #1;
      chk("s3_if_rdata", if_rdata, 32'hA0000084);
      chk("s3_d_rdata",  d_rdata,  32'hA0000304);
      pipe_advance = 1'b1; step(); pipe_advance = 1'b0; d_rd = 1'b0; if_req = 1'b0;

      // Flush: suppressed grant in IDLE, then a fetch dropped mid-wait.
      if_req = 1'b1; if_addr = 32'h500; if_flush = 1'b1; #1;
      chk("s4_flush_stall", if_stall, 32'h1);
      step(); if_flush = 1'b0; #1;
      chk("s4_idle_suppress", mem.mem_req, 32'h0);
      step();
      chk("s4_if_req",  mem.mem_req,  32'h1);
      chk("s4_if_addr", mem.mem_addr, 32'h500);
      if_flush = 1'b1; step(); if_flush = 1'b0; if_addr = 32'h600; #1;
      chk("s4_wait_req",   mem.mem_req,  32'h1);
      chk("s4_wait_addr",  mem.mem_addr, 32'h500);
      chk("s4_wait_stall", if_stall,     32'h1);
      mem.mem_ack = 1'b1; mem.mem_rdata = 32'h12345678; step(); mem.mem_ack = 1'b0; #1;
      chk("s4_drop_rdata", if_rdata,    32'hA0000084);
      chk("s4_drop_stall", if_stall,    32'h1);
      chk("s4_drop_req",   mem.mem_req, 32'h0);
      step();
      chk("s4_idle_req",   mem.mem_req, 32'h0);
      chk("s4_idle_stall", if_stall,    32'h1);
      step();
      chk("s4_new_req",  mem.mem_req,  32'h1);
      chk("s4_new_addr", mem.mem_addr, 32'h600);
      mem.mem_ack = 1'b1; mem.mem_rdata = 32'h0600AAAA; step(); mem.mem_ack = 1'b0; #1;
      chk("s4_new_rdata", if_rdata, 32'h0600AAAA);
      chk("s4_new_stall", if_stall, 32'h0);
      pipe_advance = 1'b1; step(); pipe_advance = 1'b0; if_req = 1'b0;

      // Timeout: no ack for TO wait cycles.
      d_rd = 1'b1; d_addr = 32'h700;
      step();
      for (int i = 0; i < int'(TO); i++) begin
         chk("s5_req_held", mem.mem_req, 32'h1);
         step();
      end
      chk("s5_req_dropped", mem.mem_req, 32'h0);
      chk("s5_bus_err",     bus_err,     32'h1);
      chk("s5_d_rdata",     d_rdata,     32'h0);
      chk("s5_dstall",      d_stall,     32'h0);
      step();
      chk("s5_sticky",      bus_err,     32'h1);
      chk("s5_idle_dstall", d_stall,     32'h0);
      chk("s5_idle_req",    mem.mem_req, 32'h0);
      pipe_advance = 1'b1; step(); pipe_advance = 1'b0; d_addr = 32'h800; #1;
      chk("s5_sticky_adv", bus_err, 32'h1);

      // Reset in the middle of a data wait.
      step();
      chk("s6_req",  mem.mem_req,  32'h1);
      chk("s6_addr", mem.mem_addr, 32'h800);
      rst = 1'b1; step(); #1;
      chk("s6_rst_req",    mem.mem_req, 32'h0);
      chk("s6_rst_buserr", bus_err,     32'h0);
      chk("s6_rst_dstall", d_stall,     32'h1);
      rst = 1'b0; d_rd = 1'b0;
      step();
      chk("s6_idle_req", mem.mem_req, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the pipeline's instruction fetch (IF) stage and the MEM stage.
- Issues memory transactions using a req/ack handshake.
- Generates per-stage stall signals so the pipeline freezes until its accesses are served.
- Discards fetches cancelled by branch flush and enforces IF/MEM fairness so the frozen pipeline cannot livelock.
- Sits between the datapath's IF/MEM stages and the memory model, under the pipeline top.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width
TIMEOUT, 255, max cycles waiting for mem_ack before aborting (≥1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
if_req  input  1  IF stage needs an instruction word
if_addr  input  ADDR_W  fetch PC
if_flush  input  1  branch/jump taken; cancel outstanding/served fetch
if_rdata  output  DATA_W  fetched instruction (held while if_served)
if_stall  output  1  IF access not yet served
d_rd  input  1  MEM stage load
d_wr  input  1  MEM stage store (d_rd & d_wr never both high)
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_rdata  output  DATA_W  load data (held while d_served)
d_stall  output  1  MEM access not yet served
pipe_advance  input  1  pipeline registers update this cycle
mem_req  output  1  memory request, held until ack
mem_we  output  1  write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_ack  input  1  memory completes (rdata valid) this cycle
mem_rdata  input  DATA_W  memory read data
bus_err  output  1  sticky timeout flag

Behaviour:
- Reset: state=IDLE. mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, bus_err = 0. if_served=d_served=drop=0. last_grant=IF, so D wins first tie. Wait counter = 0.
- FSM states: IDLE, IF_WAIT, D_WAIT, IF_RESP, D_RESP.
- Pending requests: if_pend = if_req & ~if_served & ~if_flush. d_pend = (d_rd|d_wr) & ~d_served.
- IDLE grant:
  - Both pending: grant the side opposite last_grant.
  - Otherwise: grant whichever is pending.
  - On grant, register mem_addr/mem_we/mem_wdata, set mem_req=1 next cycle, update last_grant, move to *_WAIT.
  - Nothing pending: stay in IDLE.
- *_WAIT:
  - mem_req and all mem_* outputs held stable.
  - Counter increments each cycle.
  - On mem_ack=1: capture mem_rdata into if_rdata or d_rdata (IF data not captured if drop=1). mem_req=0 next cycle. Go to *_RESP.
- Timeout: counter reaches TIMEOUT with no ack.
  - Set bus_err (sticky until rst).
  - Drop mem_req.
  - Load rdata=0 and go to *_RESP as if acked.
- IF_RESP:
  - drop=0: if_served=1.
  - drop=1: clear drop, no serve.
  - Then go to IDLE. Same for D_RESP with d_served=1.
- Minimum latency: request seen cycle 0, mem_req high cycle 1, ack cycle 1 earliest, served cycle 2, IDLE cycle 3.
- Stalls (combinational):
  - if_stall = if_req & ~if_served & ~(state==IF_RESP & ~drop).
  - d_stall = (d_rd|d_wr) & ~d_served & ~(state==D_RESP).
- Served flags:
  - Cleared on pipe_advance. The clear has priority over a set in the same cycle only if the set is for the already-advanced access; RESP-cycle serve plus advance leaves the flag 0.
  - While served, no re-issue. This prevents a duplicate store when MEM is served but IF still stalls.
- if_flush:
  - Clears if_served.
  - In IF_WAIT, sets drop; the memory transaction still completes, with no abort on the bus.
  - In IDLE with a simultaneous IF grant, that grant is suppressed.
  - Flush never affects D accesses.
- Reset mid-transaction: mem_req drops next cycle. The memory model must tolerate an abandoned request.

Decomposition:
- Shared package: state enum (IDLE, IF_WAIT, D_WAIT, IF_RESP, D_RESP), grant-side constants GRANT_IF/GRANT_D, default widths.
- One natural sub-module, mem_wait_timer: wait counter with clear/enable and timeout output.

Test Plan:
- Single load, mem_ack 3 cycles after mem_req rises, mem_rdata=0xDEADBEEF -> d_rdata=0xDEADBEEF. d_stall drops in D_RESP. Exactly one mem_req pulse.
- if_req and d_wr both pending from reset, no pipe_advance -> D (store, mem_we=1) granted first, then IF. The store is issued once only; d_served holds until pipe_advance.
- Continuous d_rd and if_req, pipe_advance after each pair -> grants alternate D, IF, D, IF; neither side waits more than one other transaction.
- if_flush during IF_WAIT, then ack with 0x12345678 -> if_rdata unchanged, if_served stays 0. The next if_req (new PC) is issued after the RESP/IDLE cycle.
- No mem_ack with TIMEOUT=4 -> mem_req drops after 4 wait cycles, bus_err=1 and sticky, d_rdata=0, d_stall released.
- rst asserted in D_WAIT -> next cycle mem_req=0, state IDLE, d_served=0, bus_err=0.
